// File: rtl/boot_mem_ctrl_pkg.sv
// Shared types and default widths for the boot-loading memory controller.
package boot_mem_ctrl_pkg;

    localparam int unsigned WIDTH_DEF     = 8;
    localparam int unsigned AWIDTH_DEF    = 8;
    localparam int unsigned DEPTH_DEF     = 256;
    localparam int unsigned LOAD_BASE_DEF = 0;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } boot_state_e;

endpackage

// File: rtl/boot_mem_ctrl_if.sv
// Loader byte stream plus core memory port, grouped as one bus.
interface boot_mem_ctrl_if
    import boot_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
);

    logic              ld_valid;
    logic              ld_ready;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_last;
    logic [AWIDTH-1:0] adr;
    logic [WIDTH-1:0]  writedata;
    logic              memread;
    logic              memwrite;
    logic [WIDTH-1:0]  memdata;

    // Driver side: loader source and the core.
    modport master (
        output ld_valid, ld_data, ld_last, adr, writedata, memread, memwrite,
        input  ld_ready, memdata
    );

    // Memory side.
    modport slave (
        input  ld_valid, ld_data, ld_last, adr, writedata, memread, memwrite,
        output ld_ready, memdata
    );

endinterface

// File: rtl/boot_mem_ctrl_mem_array_1w1r.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a partial image survives a reset.
module mem_array_1w1r #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; reads see the old value until this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read.
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/boot_mem_ctrl.sv
// Unified byte memory for the multicycle core with a valid/ready boot loader.
// Holds the core in reset until a complete image (ld_last, or a full array)
// has been streamed in; reload re-enters loading from LOAD_BASE.
module boot_mem_ctrl
    import boot_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned LOAD_BASE = LOAD_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    boot_mem_ctrl_if.slave    bus,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic [AWIDTH-1:0] ld_count,
    output logic              ld_ovf
);

    localparam logic [AWIDTH-1:0] BASE_ADR = AWIDTH'(LOAD_BASE);
    localparam logic [AWIDTH-1:0] LAST_CNT = AWIDTH'(DEPTH - 1);

    boot_state_e       state;
    boot_state_e       state_nxt_c;
    logic [AWIDTH-1:0] ld_ptr;
    logic              ld_ready;

    logic              beat_c;
    logic              last_free_c;
    logic              core_wr_c;
    logic              mem_we_c;
    logic [AWIDTH-1:0] mem_waddr_c;
    logic [WIDTH-1:0]  mem_wdata_c;
    logic [WIDTH-1:0]  mem_rdata_c;

    // ld_ready is only ever high in LOAD, so a beat implies LOAD.
    assign beat_c      = bus.ld_valid & ld_ready;
    assign last_free_c = (ld_count == LAST_CNT);
    assign core_wr_c   = (state == RUN) & bus.memwrite;

    // Next state: image end or a full array leaves LOAD; reload leaves RUN.
    always_comb begin
        state_nxt_c = state;
        case (state)
            LOAD: begin
                if (beat_c && (bus.ld_last || last_free_c)) begin
                    state_nxt_c = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_nxt_c = LOAD;
                end
            end
            default: state_nxt_c = LOAD;
        endcase
    end

    // Loader FSM, pointer, counter and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            ld_ptr    <= BASE_ADR;
            ld_count  <= '0;
            ld_ovf    <= 1'b0;
            ld_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            boot_done <= 1'b0;
        end else begin
            state     <= state_nxt_c;
            ld_ready  <= (state_nxt_c == LOAD);
            cpu_reset <= (state_nxt_c != RUN);
            boot_done <= (state_nxt_c == RUN);
            if (beat_c) begin
                ld_ptr <= ld_ptr + AWIDTH'(1);
                // Count saturates; a genuine overflow shows up only on ld_ovf.
                if (!last_free_c) begin
                    ld_count <= ld_count + AWIDTH'(1);
                end else if (!bus.ld_last) begin
                    ld_ovf <= 1'b1;
                end
            end
            if (state == RUN && reload) begin
                ld_ptr   <= BASE_ADR;
                ld_count <= '0;
            end
        end
    end

    // Write port mux: loader owns the array in LOAD, the core in RUN.
    always_comb begin
        mem_we_c    = beat_c | core_wr_c;
        mem_waddr_c = ld_ptr;
        mem_wdata_c = bus.ld_data;
        if (state == RUN) begin
            mem_waddr_c = bus.adr;
            mem_wdata_c = bus.writedata;
        end
    end

    mem_array_1w1r #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (mem_waddr_c),
        .wdata   (mem_wdata_c),
        .raddr   (bus.adr),
        .rdata_c (mem_rdata_c)
    );

    // Core read data is gated to zero outside RUN or without memread.
    assign bus.memdata  = (state == RUN && bus.memread) ? mem_rdata_c : '0;
    assign bus.ld_ready = ld_ready;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Bench for boot_mem_ctrl: directed scenarios plus randomized loads and core
// traffic, checked every cycle against a behavioural model of the memory.
module tb_boot_mem_ctrl;
    import boot_mem_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reload = 1'b0;
    logic       cpu_reset;
    logic       boot_done;
    logic [7:0] ld_count;
    logic       ld_ovf;

    boot_mem_ctrl_if #(.WIDTH(8), .AWIDTH(8)) bus ();

    boot_mem_ctrl #(
        .WIDTH(8), .AWIDTH(8), .DEPTH(256), .LOAD_BASE(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reload    (reload),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .boot_done (boot_done),
        .ld_count  (ld_count),
        .ld_ovf    (ld_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [256];
    bit         m_known [256];
    bit         m_run   = 0;
    bit         m_ready = 0;
    bit         m_ovf   = 0;
    int         m_ptr   = 0;
    int         m_acc   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_ready = 0; m_ovf = 0; m_ptr = 0; m_acc = 0;
        end else if (!m_run) begin
            if (m_ready && bus.ld_valid) begin
                m_mem[m_ptr]   = bus.ld_data;
                m_known[m_ptr] = 1;
                m_ptr = (m_ptr + 1) % 256;
                m_acc = m_acc + 1;
                if (bus.ld_last) m_run = 1;
                else if (m_acc == 256) begin
                    m_run = 1;
                    m_ovf = 1;
                end
            end
            m_ready = !m_run;
        end else begin
            if (bus.memwrite) begin
                m_mem[bus.adr]   = bus.writedata;
                m_known[bus.adr] = 1;
            end
            if (reload) begin
                m_run = 0; m_ptr = 0; m_acc = 0; m_ready = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, !m_run});
        chk("boot_done", {31'd0, boot_done}, {31'd0, m_run});
        chk("ld_ready",  {31'd0, bus.ld_ready}, {31'd0, m_ready});
        chk("ld_count",  {24'd0, ld_count}, (m_acc > 255) ? 32'd255 : 32'(m_acc));
        chk("ld_ovf",    {31'd0, ld_ovf}, {31'd0, m_ovf});
        if (m_run && bus.memread) begin
            if (m_known[bus.adr]) chk("memdata", {24'd0, bus.memdata}, {24'd0, m_mem[bus.adr]});
        end else begin
            chk("memdata_zero", {24'd0, bus.memdata}, 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] img_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
        bus.adr = 0; bus.writedata = 0; bus.memread = 0; bus.memwrite = 0;
        reload = 0;
    endtask

    // Stream img_q into the loader; ld_last rides on the final byte.
    task automatic do_load(input bit gaps);
        int  idx = 0;
        int  budget = 4 * img_q.size() + 20;
        bit  b;
        while (idx < img_q.size() && budget > 0) begin
            bus.ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.ld_data  = img_q[idx];
            bus.ld_last  = (idx == img_q.size() - 1);
            @(negedge clk);
            b = bus.ld_valid && bus.ld_ready;
            step();
            if (b) idx++;
            budget--;
        end
        bus.ld_valid = 0;
        bus.ld_last  = 0;
        if (idx < img_q.size()) chk("load_timeout", 32'(idx), 32'(img_q.size()));
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        bus.adr = a; bus.memread = 1;
        #1;
        chk(name, {24'd0, bus.memdata}, {24'd0, exp});
        bus.memread = 0;
    endtask

    initial begin
        idle_inputs();
        step();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_ld_ready",  {31'd0, bus.ld_ready}, 32'd0);
        chk("rst_ld_count",  {24'd0, ld_count}, 32'd0);
        step();
        reset = 1;
        #1;
        chk("ready_after_release", {31'd0, bus.ld_ready}, 32'd0);
        step();
        chk("ready_first_clock", {31'd0, bus.ld_ready}, 32'd1);

        // 1: four-byte image
        img_q = '{8'h80, 8'h02, 8'h04, 8'h44};
        do_load(0);
        chk("s1_boot_done", {31'd0, boot_done}, 32'd1);
        chk("s1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("s1_ld_count",  {24'd0, ld_count}, 32'd4);
        rd(8'h00, 8'h80, "s1_mem0");
        rd(8'h03, 8'h44, "s1_mem3");

        // 2: same-cycle read, then memread low
        rd(8'h02, 8'h04, "s2_read");
        #1;
        chk("s2_memread_low", {24'd0, bus.memdata}, 32'd0);

        // 3: read-during-write returns the old byte
        bus.adr = 8'h10; bus.writedata = 8'h3C; bus.memwrite = 1;
        step();
        bus.writedata = 8'hA5; bus.memread = 1;
        #1;
        chk("s3_old_byte", {24'd0, bus.memdata}, 32'h3C);
        step();
        bus.memwrite = 0;
        #1;
        chk("s3_new_byte", {24'd0, bus.memdata}, 32'hA5);
        bus.memread = 0;

        // 4: full array without ld_last overflows
        reload = 1;
        step();
        reload = 0;
        bus.ld_valid = 1; bus.ld_last = 0;
        for (int i = 0; i < 256; i++) begin
            bus.ld_data = 8'(i ^ 8'h5A);
            step();
        end
        chk("s4_ovf",       {31'd0, ld_ovf}, 32'd1);
        chk("s4_boot_done", {31'd0, boot_done}, 32'd1);
        chk("s4_ld_count",  {24'd0, ld_count}, 32'd255);
        chk("s4_no_257th",  {31'd0, bus.ld_ready}, 32'd0);
        step();
        bus.ld_valid = 0;
        rd(8'h00, 8'h5A, "s4_mem0");
        rd(8'hFF, 8'hA5, "s4_memff");

        // 5: reload together with a core write
        bus.adr = 8'h20; bus.writedata = 8'h11; bus.memwrite = 1; reload = 1;
        step();
        bus.memwrite = 0; reload = 0;
        chk("s5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("s5_ld_count",  {24'd0, ld_count}, 32'd0);
        chk("s5_ovf_kept",  {31'd0, ld_ovf}, 32'd1);
        img_q = '{8'hFF};
        do_load(0);
        chk("s5_boot_done", {31'd0, boot_done}, 32'd1);
        rd(8'h00, 8'hFF, "s5_mem0");
        rd(8'h20, 8'h11, "s5_mem20");

        // 6: reset mid-load, then reload from the base
        reload = 1;
        step();
        reload = 0;
        bus.ld_valid = 1;
        bus.ld_data = 8'h11; step();
        bus.ld_data = 8'h22; step();
        reset = 0;
        #1;
        chk("s6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("s6_boot_done", {31'd0, boot_done}, 32'd0);
        chk("s6_ld_ready",  {31'd0, bus.ld_ready}, 32'd0);
        chk("s6_ld_count",  {24'd0, ld_count}, 32'd0);
        chk("s6_ld_ovf",    {31'd0, ld_ovf}, 32'd0);
        bus.ld_valid = 0;
        step();
        reset = 1;
        step();
        img_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        do_load(1);
        chk("s6_ld_count4", {24'd0, ld_count}, 32'd4);
        rd(8'h00, 8'h55, "s6_mem0");
        rd(8'h01, 8'h66, "s6_mem1");

        // Randomized loads and core traffic.
        for (int it = 0; it < 8; it++) begin
            if (m_run) begin
                reload = 1;
                step();
                reload = 0;
            end
            img_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 40)); k++) img_q.push_back(8'($urandom));
            do_load(1);
            for (int c = 0; c < 60; c++) begin
                bus.adr       = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 47)) : 8'($urandom);
                bus.writedata = 8'($urandom);
                bus.memread   = 1'($urandom);
                bus.memwrite  = ($urandom_range(0, 3) == 0);
                bus.ld_valid  = ($urandom_range(0, 7) == 0);
                bus.ld_data   = 8'($urandom);
                reload        = ($urandom_range(0, 49) == 0);
                step();
            end
            idle_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
